endgame_ctrl: RTL

Game-session sequencer that drives the end-of-game popup path. It owns the round state, the centisecond game timer and the discovered-pairs counter. When the round ends by win or timeout, it freezes the results and raises the popup enable after a short delay. A confirm press then dismisses the popup and requests a new board. It sits between the board/input logic and the endgame popup renderer; its outputs feed that renderer's `enable`, `game_over_en`, `discovered_pairs_ctr` and `game_time` inputs directly.

---
 rtl/endgame_ctrl_pkg.sv | 46 ++++
 rtl/endgame_ctrl_cs_tick_gen.sv | 45 ++++
 rtl/endgame_ctrl.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/endgame_ctrl_pkg.sv
// endgame_ctrl_pkg
// Shared definitions for the end-of-game sequencer:
//   - default round parameters (pairs to win, time limit in seconds)
//   - FSM state encoding
//   - game_time field layout {seconds[12:7], hundredths[6:0]} and helpers
package endgame_ctrl_pkg;

    localparam int unsigned TOTAL_PAIRS_DEF  = 8;
    localparam int unsigned TIME_LIMIT_S_DEF = 60;

    localparam int unsigned TIME_W = 13;
    localparam int unsigned SEC_W  = 6;
    localparam int unsigned HUN_W  = 7;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_PLAY      = 3'd1,
        ST_END_DELAY = 3'd2,
        ST_POPUP     = 3'd3,
        ST_CLEANUP   = 3'd4
    } state_e;

    function automatic logic [SEC_W-1:0] time_sec(input logic [TIME_W-1:0] t);
        return t[12:7];
    endfunction

    function automatic logic [HUN_W-1:0] time_hun(input logic [TIME_W-1:0] t);
        return t[6:0];
    endfunction

    // One centisecond step: hundredths wrap 99 -> 0 and carry into seconds.
    function automatic logic [TIME_W-1:0] time_advance(input logic [TIME_W-1:0] t);
        logic [SEC_W-1:0] sec;
        logic [HUN_W-1:0] hun;
        sec = time_sec(t);
        hun = time_hun(t);
        if (hun == 7'd99) begin
            sec = sec + 6'd1;
            hun = 7'd0;
        end else begin
            hun = hun + 7'd1;
        end
        return {sec, hun};
    endfunction

endpackage

// File: rtl/endgame_ctrl_cs_tick_gen.sv
// cs_tick_gen
// Centisecond prescaler: counts 0..CLK_FREQ_HZ/100-1 while run is high and
// pulses tick for one cycle on the terminal count.
// Ports:
//   pclk  - clock
//   rst_n - asynchronous active-low reset
//   clr   - synchronous clear of the prescaler (wins over run)
//   run   - advance the prescaler this cycle
//   tick  - one-cycle centisecond pulse
module cs_tick_gen #(
    parameter int unsigned CLK_FREQ_HZ = 65_000_000
) (
    input  logic pclk,
    input  logic rst_n,
    input  logic clr,
    input  logic run,
    output logic tick
);

    localparam int unsigned DIV   = CLK_FREQ_HZ / 100;
    localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (run) begin
            cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = run && !clr && (cnt_q == LAST);

endmodule

// File: rtl/endgame_ctrl.sv
// endgame_ctrl
// Round sequencer for the end-of-game popup path. Owns the round FSM, the
// centisecond game timer, the discovered-pairs counter and the shared
// delay/holdoff counter. All outputs are registered.
// Handshake: start, pair_found and btn_confirm are single-cycle pulses with
// no back-pressure; each is consumed only in its accepting state (start in
// IDLE, pair_found in PLAY, btn_confirm in POPUP after the holdoff) and is
// otherwise dropped.
// Ports:
//   pclk, rst_n          - clock, asynchronous active-low reset
//   start                - begin a round (IDLE only)
//   pair_found           - matched pair reported by the board (PLAY only)
//   btn_confirm          - dismiss popup (POPUP after holdoff only)
//   game_active          - round in progress
//   popup_en             - popup renderer enable
//   game_over_en         - 1 = lost by timeout, 0 = won
//   discovered_pairs_ctr - pairs found
//   game_time            - {seconds[12:7], hundredths[6:0]}
//   new_game             - one-cycle reshuffle request
//   dbg_state_o          - current FSM state
module endgame_ctrl
    import endgame_ctrl_pkg::*;
#(
    parameter int unsigned CLK_FREQ_HZ        = 65_000_000,
    parameter int unsigned TOTAL_PAIRS        = TOTAL_PAIRS_DEF,
    parameter int unsigned TIME_LIMIT_S       = TIME_LIMIT_S_DEF,
    parameter int unsigned POPUP_DELAY_CS     = 50,
    parameter int unsigned DISMISS_HOLDOFF_CS = 100
) (
    input  logic              pclk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              pair_found,
    input  logic              btn_confirm,
    output logic              game_active,
    output logic              popup_en,
    output logic              game_over_en,
    output logic [7:0]        discovered_pairs_ctr,
    output logic [TIME_W-1:0] game_time,
    output logic              new_game,
    output state_e            dbg_state_o
);

    localparam logic [7:0]        PAIRS_WIN  = 8'(TOTAL_PAIRS);
    localparam logic [TIME_W-1:0] TIME_LIMIT = {6'(TIME_LIMIT_S), 7'd0};
    localparam logic [15:0]       DELAY_LAST = 16'(POPUP_DELAY_CS - 1);
    localparam logic [15:0]       HOLDOFF    = 16'(DISMISS_HOLDOFF_CS);

    state_e            state_q, state_d;
    logic [TIME_W-1:0] time_q, time_d;
    logic [7:0]        pairs_q, pairs_d;
    logic              over_q, over_d;
    logic [15:0]       dly_q, dly_d;
    logic              active_q, popup_q, new_game_q;
    logic              presc_clr, presc_run, tick;

    assign presc_run = (state_q == ST_PLAY) || (state_q == ST_END_DELAY) ||
                       (state_q == ST_POPUP);

    cs_tick_gen #(
        .CLK_FREQ_HZ(CLK_FREQ_HZ)
    ) u_tick (
        .pclk (pclk),
        .rst_n(rst_n),
        .clr  (presc_clr),
        .run  (presc_run),
        .tick (tick)
    );

    always_comb begin
        state_d   = state_q;
        time_d    = time_q;
        pairs_d   = pairs_q;
        over_d    = over_q;
        dly_d     = dly_q;
        presc_clr = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    time_d    = '0;
                    pairs_d   = '0;
                    over_d    = 1'b0;
                    presc_clr = 1'b1;
                    state_d   = ST_PLAY;
                end
            end
            ST_PLAY: begin
                if (tick) time_d = time_advance(time_q);
                if (pair_found) pairs_d = pairs_q + 8'd1;
                // Win beats timeout on the same cycle; the time step still lands.
                if (pair_found && (pairs_q + 8'd1 == PAIRS_WIN)) begin
                    over_d  = 1'b0;
                    dly_d   = '0;
                    state_d = ST_END_DELAY;
                end else if (tick && (time_d == TIME_LIMIT)) begin
                    over_d  = 1'b1;
                    dly_d   = '0;
                    state_d = ST_END_DELAY;
                end
            end
            ST_END_DELAY: begin
                if (tick) begin
                    if (dly_q == DELAY_LAST) begin
                        dly_d   = '0;
                        state_d = ST_POPUP;
                    end else begin
                        dly_d = dly_q + 16'd1;
                    end
                end
            end
            ST_POPUP: begin
                // Counter saturates at the holdoff; only then is confirm honoured.
                if (dly_q >= HOLDOFF) begin
                    if (btn_confirm) state_d = ST_CLEANUP;
                end else if (tick) begin
                    dly_d = dly_q + 16'd1;
                end
            end
            ST_CLEANUP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            time_q     <= '0;
            pairs_q    <= '0;
            over_q     <= 1'b0;
            dly_q      <= '0;
            active_q   <= 1'b0;
            popup_q    <= 1'b0;
            new_game_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            time_q     <= time_d;
            pairs_q    <= pairs_d;
            over_q     <= over_d;
            dly_q      <= dly_d;
            active_q   <= (state_d == ST_PLAY);
            popup_q    <= (state_d == ST_POPUP);
            new_game_q <= (state_d == ST_CLEANUP);
        end
    end

    assign game_active          = active_q;
    assign popup_en             = popup_q;
    assign game_over_en         = over_q;
    assign discovered_pairs_ctr = pairs_q;
    assign game_time            = time_q;
    assign new_game             = new_game_q;
    assign dbg_state_o          = state_q;

endmodule
